// File: rtl/cu_hmi_multi.sv
// Host-link command decoder: synchronises din_rdy, decodes single/two-byte commands
// and emits one-clock Moore command pulses, with optional gating on device select.
module cu_hmi_multi #(
   parameter int DEV_AW     = 3,
   parameter int PKT_AW     = 5,
   parameter int SYNC_DEPTH = 4,
   parameter int TMO_CYC    = 255,
   parameter int GATE_SEL   = 0
) (
   input  logic                  clk,
   input  logic                  res,
   input  logic                  din_rdy,
   input  logic [7:0]            din,
   input  logic [DEV_AW-1:0]     dev_addr,
   output logic                  cmd_reset,
   output logic                  cmd_rst_dac,
   output logic                  cmd_inc_dac,
   output logic                  cmd_rst_test,
   output logic                  cmd_startup,
   output logic                  cmd_read,
   output logic                  cmd_dac_wr,
   output logic                  cmd_err,
   output logic                  busy,
   output logic [7:0]            dac_val,
   output logic [PKT_AW-1:0]     pkt_addr,
   output logic                  cmd_dev_sel,
   output logic [2*DEV_AW+1:0]   dev_sel_byte
);

   typedef enum logic [3:0] {
      S_IDLE, S_CHECK, S_ADDRS, S_READ, S_CMD, S_SELFPGA, S_RESET, S_RES_DAC,
      S_INC_DAC, S_RES_TEST, S_STARTUP, S_ARG_WAIT, S_ARG_LOAD, S_DAC_WR, S_ERR
   } state_t;

   localparam logic [15:0] TMO = 16'(TMO_CYC);

   state_t                  state_q, state_d;
   logic [SYNC_DEPTH-1:0]   shift_q, shift_d;
   logic [7:0]              data_q, data_d;
   logic [15:0]             timer_q, timer_d;
   logic [PKT_AW-1:0]       pkt_q, pkt_d;
   logic [7:0]              dac_q, dac_d;
   logic [DEV_AW-1:0]       dar_q, dar_d;
   logic                    ovr_q, ovr_d;

   logic                    strobe;
   logic                    accept;
   logic                    pulse_en;

   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         state_q <= S_IDLE;
         shift_q <= '0;
         data_q  <= '0;
         timer_q <= '0;
         pkt_q   <= '0;
         dac_q   <= '0;
         dar_q   <= '1;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         timer_q <= timer_d;
         pkt_q   <= pkt_d;
         dac_q   <= dac_d;
         dar_q   <= dar_d;
         ovr_q   <= ovr_d;
      end
   end

   always_comb begin
      shift_d = {shift_q[SYNC_DEPTH-2:0], din_rdy};
      strobe  = shift_q[SYNC_DEPTH-2] & ~shift_q[SYNC_DEPTH-1];
      accept  = (state_q == S_IDLE) || (state_q == S_ARG_WAIT);
      data_d  = (strobe && accept) ? din : data_q;
      // A byte arriving mid-command is discarded and flagged one clock later.
      ovr_d   = strobe && !accept;

      state_d = state_q;
      timer_d = '0;
      pkt_d   = pkt_q;
      dac_d   = dac_q;
      dar_d   = dar_q;

      case (state_q)
         S_IDLE:    if (strobe) state_d = S_CHECK;
         S_CHECK: begin
            case (data_q[7:6])
               2'b10:   state_d = S_ADDRS;
               2'b01:   state_d = S_CMD;
               2'b11:   state_d = S_SELFPGA;
               default: state_d = S_ERR;
            endcase
         end
         S_ADDRS: begin
            pkt_d   = data_q[PKT_AW-1:0];
            state_d = S_READ;
         end
         S_SELFPGA: begin
            dar_d   = data_q[DEV_AW-1:0];
            state_d = S_IDLE;
         end
         S_CMD: begin
            case (data_q[2:0])
               3'd1:    state_d = S_RESET;
               3'd2:    state_d = S_RES_DAC;
               3'd3:    state_d = S_INC_DAC;
               3'd4:    state_d = S_ARG_WAIT;
               3'd5:    state_d = S_RES_TEST;
               3'd6:    state_d = S_STARTUP;
               default: state_d = S_ERR;
            endcase
         end
         S_ARG_WAIT: begin
            if (strobe) begin
               state_d = S_ARG_LOAD;
            end else if (timer_q >= TMO) begin
               state_d = S_ERR;
            end else begin
               timer_d = (timer_q == '1) ? timer_q : timer_q + 16'd1;
            end
         end
         S_ARG_LOAD: begin
            dac_d   = data_q;
            state_d = S_DAC_WR;
         end
         default:   state_d = S_IDLE;
      endcase
   end

   assign cmd_dev_sel  = (dar_q == dev_addr);
   assign dev_sel_byte = {cmd_dev_sel, dar_q, 1'b0, dev_addr};
   assign pulse_en     = (GATE_SEL == 0) || cmd_dev_sel;

   assign cmd_reset    = pulse_en && (state_q == S_RESET);
   assign cmd_rst_dac  = pulse_en && (state_q == S_RES_DAC);
   assign cmd_inc_dac  = pulse_en && (state_q == S_INC_DAC);
   assign cmd_rst_test = pulse_en && (state_q == S_RES_TEST);
   assign cmd_startup  = pulse_en && (state_q == S_STARTUP);
   assign cmd_read     = pulse_en && (state_q == S_READ);
   assign cmd_dac_wr   = pulse_en && (state_q == S_DAC_WR);
   assign cmd_err      = (state_q == S_ERR) || ovr_q;
   assign busy         = (state_q != S_IDLE);
   assign dac_val      = dac_q;
   assign pkt_addr     = pkt_q;

endmodule

// File: tb/tb_cu_hmi_multi.sv
// Scoreboard bench: two decoders (ungated and gated) share one host byte stream.
module tb_cu_hmi_multi;

   localparam int SD  = 4;
   localparam int TMO = 20;
   localparam logic [7:0] EV_RST   = 8'h01;
   localparam logic [7:0] EV_INC   = 8'h04;
   localparam logic [7:0] EV_READ  = 8'h20;
   localparam logic [7:0] EV_DACWR = 8'h40;
   localparam logic [7:0] EV_ERR   = 8'h80;

   typedef struct packed {
      logic [7:0] ev;
      logic [4:0] pkt;
      logic [7:0] dac;
      logic [7:0] dsb;
      int         cyc;
   } item_t;

   logic       clk = 1'b0;
   logic       res;
   logic       din_rdy;
   logic [7:0] din;
   logic [2:0] dev_addr;

   logic       r0, rd0, i0, rt0, st0, rr0, dw0, e0, b0, s0;
   logic [7:0] dv0, dsb0;
   logic [4:0] pk0;
   logic       r1, rd1, i1, rt1, st1, rr1, dw1, e1, b1, s1;
   logic [7:0] dv1, dsb1;
   logic [4:0] pk1;

   item_t q0[$];
   item_t q1[$];
   int    cyc = 0;
   int    tests = 0;
   int    fails = 0;
   logic  stim_done = 1'b0;
   logic [4:0] m_pkt;
   logic [7:0] m_dac;
   logic [2:0] m_dar;

   cu_hmi_multi #(.DEV_AW(3), .PKT_AW(5), .SYNC_DEPTH(SD), .TMO_CYC(TMO), .GATE_SEL(0)) dut0 (
      .clk(clk), .res(res), .din_rdy(din_rdy), .din(din), .dev_addr(dev_addr),
      .cmd_reset(r0), .cmd_rst_dac(rd0), .cmd_inc_dac(i0), .cmd_rst_test(rt0),
      .cmd_startup(st0), .cmd_read(rr0), .cmd_dac_wr(dw0), .cmd_err(e0), .busy(b0),
      .dac_val(dv0), .pkt_addr(pk0), .cmd_dev_sel(s0), .dev_sel_byte(dsb0));

   cu_hmi_multi #(.DEV_AW(3), .PKT_AW(5), .SYNC_DEPTH(SD), .TMO_CYC(TMO), .GATE_SEL(1)) dut1 (
      .clk(clk), .res(res), .din_rdy(din_rdy), .din(din), .dev_addr(dev_addr),
      .cmd_reset(r1), .cmd_rst_dac(rd1), .cmd_inc_dac(i1), .cmd_rst_test(rt1),
      .cmd_startup(st1), .cmd_read(rr1), .cmd_dac_wr(dw1), .cmd_err(e1), .busy(b1),
      .dac_val(dv1), .pkt_addr(pk1), .cmd_dev_sel(s1), .dev_sel_byte(dsb1));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
      tests++;
      if (act !== exp_v) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp_v, cyc);
      end
   endtask

   task automatic mon(input int d, input logic [7:0] ev, input logic bsy, input logic sel,
                      input logic [4:0] pk, input logic [7:0] dv, input logic [7:0] dsb);
      item_t it;
      if (res) begin
         chk($sformatf("dut%0d reset state", d), {2'b0, ev, bsy, sel, pk, dv, dsb},
             {2'b0, 8'h00, 1'b0, 1'b0, 5'h00, 8'h00, 8'h72});
         return;
      end
      while (((d == 0) ? q0.size() : q1.size()) > 0 &&
             ((d == 0) ? q0[0].cyc : q1[0].cyc) < cyc) begin
         it = (d == 0) ? q0.pop_front() : q1.pop_front();
         tests++;
         fails++;
         $display("FAIL dut%0d missed event: got none, expected ev=%0h at cycle %0d", d, it.ev, it.cyc);
      end
      if (ev != 8'h00) begin
         if (((d == 0) ? q0.size() : q1.size()) > 0 &&
             ((d == 0) ? q0[0].cyc : q1[0].cyc) == cyc) begin
            it = (d == 0) ? q0.pop_front() : q1.pop_front();
            chk($sformatf("dut%0d pulses", d), {24'h0, ev}, {24'h0, it.ev});
            chk($sformatf("dut%0d busy", d), {31'h0, bsy}, 32'h1);
            chk($sformatf("dut%0d pkt_addr", d), {27'h0, pk}, {27'h0, it.pkt});
            chk($sformatf("dut%0d dac_val", d), {24'h0, dv}, {24'h0, it.dac});
            chk($sformatf("dut%0d dev_sel_byte", d), {24'h0, dsb}, {24'h0, it.dsb});
         end else begin
            tests++;
            fails++;
            $display("FAIL dut%0d unexpected event: got ev=%0h at cycle %0d, expected none", d, ev, cyc);
         end
      end
   endtask

   always @(negedge clk) begin
      mon(0, {e0, dw0, rr0, st0, rt0, i0, rd0, r0}, b0, s0, pk0, dv0, dsb0);
      mon(1, {e1, dw1, rr1, st1, rt1, i1, rd1, r1}, b1, s1, pk1, dv1, dsb1);
      if (stim_done || cyc > 3000) begin
         if (!stim_done) begin
            tests++;
            fails++;
            $display("FAIL watchdog: got cycle %0d, expected stimulus done", cyc);
         end
         tests++;
         if (q0.size() + q1.size() != 0) begin
            fails++;
            $display("FAIL leftover events: got %0d pending, expected 0", q0.size() + q1.size());
         end
         $display("[TB] %0d tests run, %0d failed", tests, fails);
         $finish;
      end
   end

   task automatic push(input int d, input logic [7:0] ev, input int c);
      item_t it;
      it.ev  = ev;
      it.pkt = m_pkt;
      it.dac = m_dac;
      it.dsb = {(m_dar == 3'd2), m_dar, 1'b0, 3'd2};
      it.cyc = c;
      if (d == 0) q0.push_back(it);
      else q1.push_back(it);
   endtask

   // Raises din_rdy with a new byte; s is the cycle the decoder sees the strobe.
   task automatic send(input logic [7:0] b, output int s);
      @(posedge clk);
      #1;
      din     = b;
      din_rdy = 1'b1;
      s       = cyc + SD - 1;
   endtask

   task automatic settle(input int gap);
      repeat (SD) @(posedge clk);
      #1 din_rdy = 1'b0;
      repeat (gap) @(posedge clk);
   endtask

   initial begin
      int s;
      int a;
      res = 1'b1; din_rdy = 1'b0; din = 8'h00; dev_addr = 3'd2;
      m_pkt = '0; m_dac = '0; m_dar = '1;
      repeat (3) @(posedge clk);
      #1 res = 1'b0;

      send(8'h41, s); push(0, EV_RST, s + 3); settle(6);
      send(8'h95, s); m_pkt = 5'h15; push(0, EV_READ, s + 3); settle(6);

      send(8'h44, s); settle(2);
      send(8'hA7, a); m_dac = 8'hA7; push(0, EV_DACWR, a + 2); settle(6);

      send(8'h44, s); push(0, EV_ERR, s + 4 + TMO); push(1, EV_ERR, s + 4 + TMO); settle(TMO + 8);

      send(8'h07, s); push(0, EV_ERR, s + 2); push(1, EV_ERR, s + 2); settle(6);
      send(8'h40, s); push(0, EV_ERR, s + 3); push(1, EV_ERR, s + 3); settle(6);
      send(8'h47, s); push(0, EV_ERR, s + 3); push(1, EV_ERR, s + 3); settle(6);

      // Second strobe lands in CMD: dropped, overrun flagged with the reset pulse.
      send(8'h41, s);
      push(0, EV_RST | EV_ERR, s + 3); push(1, EV_ERR, s + 3);
      @(posedge clk); #1 din_rdy = 1'b0;
      @(posedge clk); #1 din_rdy = 1'b1;
      repeat (2) @(posedge clk);
      #1 din = 8'h95;
      settle(6);

      send(8'h43, s); push(0, EV_INC, s + 3); settle(6);
      send(8'hC2, s); settle(6); m_dar = 3'd2;
      send(8'h43, s); push(0, EV_INC, s + 3); push(1, EV_INC, s + 3); settle(6);

      send(8'h44, s); settle(2);
      @(posedge clk); #1 res = 1'b1;
      repeat (2) @(posedge clk);
      #1 res = 1'b0;
      m_pkt = '0; m_dac = '0; m_dar = '1;
      repeat (4) @(posedge clk);
      send(8'h41, s); push(0, EV_RST, s + 3); settle(8);

      stim_done = 1'b1;
   end

endmodule
